// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD adder.
// Used by bcd_digit_add and bcd_serial_adder.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  function automatic logic digit_bad(
    input logic [BCD_DIGIT_W-1:0] d
  );
    return d > BCD_DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with decimal carry in and out.
// One instance is time-shared across all digits by bcd_serial_adder.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] da,
  input  logic [BCD_DIGIT_W-1:0] db,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] dsum,
  output logic                   co
);

  logic [BCD_DIGIT_W:0] t;

  always_comb begin
    t = {1'b0, da} + {1'b0, db}
      + {{BCD_DIGIT_W{1'b0}}, ci};
    if (t > (BCD_DIGIT_W+1)'(BCD_MAX)) begin
      dsum = t[BCD_DIGIT_W-1:0]
           + BCD_DIGIT_W'(BCD_CORR);
      co   = 1'b1;
    end else begin
      dsum = t[BCD_DIGIT_W-1:0];
      co   = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, LSD first, one digit per cycle.
// Define BCD_INPUT_CHECK_EN to add the err port flagging non-BCD inputs.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          busy
`ifdef BCD_INPUT_CHECK_EN
  ,
  output logic                          err
`endif
);

  localparam int W  = BCD_DIGIT_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q, sum_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic          last;

  logic [BCD_DIGIT_W-1:0] da, db, dsum;
  logic                   co;

  assign last = idx_q == IW'(DIGITS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = ADD;
      ADD:  if (last)      state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      ADD:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand digit select for the shared single-digit adder.
  always_comb begin
    da = '0;
    db = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        da = a_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        db = b_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  bcd_digit_add u_digit (
    .da   (da),
    .db   (db),
    .ci   (carry_q),
    .dsum (dsum),
    .co   (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          idx_q   <= '0;
          sum_q   <= '0;
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i))
              sum_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= dsum;
          end
          carry_q <= co;
          if (!last) idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

`ifdef BCD_INPUT_CHECK_EN
  logic err_q;
  logic bad;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          digit_bad(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (state_q == IDLE && in_valid)
      err_q <= bad;
  end

  assign err = err_q;
`endif

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial multi-digit packed-BCD adder with valid/ready handshakes on both sides. It accepts two DIGITS-wide packed BCD operands plus a carry-in, then adds them one digit per cycle, least-significant digit first, through a single-digit BCD add stage. It returns the packed BCD sum and a decimal carry-out. It is the sequencing stage in front of the single-digit BCD add logic, trading latency for area versus a fully parallel multi-digit adder.

## Interface
- DIGITS, default 4: number of BCD digits per operand; minimum 1.
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: operands a, b and cin are valid.
- in_ready  output  1: block can accept operands; high only in IDLE.
- a  input  4*DIGITS: operand A, packed BCD, digit 0 at bits [3:0].
- b  input  4*DIGITS: operand B, same packing as a.
- cin  input  1: decimal carry-in to digit 0.
- out_valid  output  1: sum and cout valid; high only in DONE.
- out_ready  input  1: consumer accepts the result.
- sum  output  4*DIGITS: packed BCD sum.
- cout  output  1: decimal carry-out of the most-significant digit.
- busy  output  1: high in ADD or DONE.
- err  output  1: invalid input digit flag; present only with BCD_INPUT_CHECK_EN.

## Operation
- FSM states are IDLE, ADD and DONE.
- IDLE: in_ready=1. When in_valid is high at a clock edge:
  - capture a, b and cin into internal registers;
  - clear the digit index to 0;
  - clear the sum register;
  - go to ADD.
- ADD: each cycle processes digit idx.
  - t = A[idx] + B[idx] + carry, computed 5 bits wide, so t is at most 19.
  - If t > 9: digit = (t + 6) mod 16 and carry = 1.
  - Otherwise: digit = t and carry = 0.
  - sum[idx] is written with the digit and the carry register is updated.
  - If idx == DIGITS-1, go to DONE; otherwise increment idx.
- DONE: out_valid=1, and sum and cout are held stable. When out_ready is high at a clock edge, go to IDLE.
- In ADD and DONE, in_valid is ignored (in_ready=0).
- Non-BCD digits (>9) without the check macro: the same arithmetic is applied. The result is deterministic but not meaningful.
- The sum output is registered and reflects partial results during ADD. It is meaningful only while out_valid=1.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, busy=0, err=0, state=IDLE, idx=0, carry=0.
- Reset is asynchronous. Assertion at any point, including mid-ADD or in DONE, aborts the operation immediately with no partial result emitted.
- Latency: out_valid rises DIGITS clock edges after the accepting edge.
- Minimum spacing between accepts is DIGITS+2 cycles: one IDLE cycle, DIGITS ADD cycles, at least one DONE cycle.
- The DONE→IDLE edge always passes through IDLE. There is no accept on the same edge as result consumption.
- in_ready, out_valid and busy are decoded from registered state only. There are no combinational paths from any input to any output.
- Backpressure: with out_ready held low, the block stays in DONE indefinitely with outputs frozen.
- DIGITS=1: ADD lasts exactly one cycle.

## Configuration
- BCD_INPUT_CHECK_EN defined:
  - At the accepting edge, err_reg is set if any digit of a or b is greater than 9. It is otherwise cleared.
  - err is driven from err_reg. It is meaningful alongside out_valid and holds until the next accept.
  - The sum is still computed per the Operation rules.
- BCD_INPUT_CHECK_EN undefined: the err port and all checking logic are absent.

## Structure
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4, BCD_MAX=9, BCD_CORR=6;
  - the typedef for the FSM state enum (IDLE, ADD, DONE).
- Sub-module bcd_digit_add: combinational, one digit. Inputs are two 4-bit digits and a carry-in; outputs are a 4-bit digit and a carry-out. It is instantiated once and muxed by idx.
- The top level holds the FSM, operand registers, index counter, carry register and sum register.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0 → sum=0x6912, cout=0; out_valid exactly 4 edges after accept.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1; carry ripples through all digits.
- a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1 (19999).
- Backpressure: out_ready low for 5 cycles after out_valid, with in_valid pulsed meanwhile → sum and cout stable, in_ready=0, no new capture; result consumed on the first out_ready edge, then IDLE.
- Assert rst_n low after 2 ADD cycles → all outputs at reset values immediately; after release, a new operation a=0x0005, b=0x0005 gives sum=0x0010.
- With BCD_INPUT_CHECK_EN: a=0x12A4, b=0x0000 → err=1 with out_valid; next operation a=0x0001, b=0x0001 → err=0, sum=0x0002.
